// File: rtl/run_ctrl_fsm.sv
// Run controller: latches a run length on start, counts engine cycles, and supports pause/resume,
// early stop, abort, a programmable DONE hold time and optional back-to-back auto-restart.
module run_ctrl_fsm #(
  parameter int CNT_W        = 16,
  parameter int DONE_HOLD    = 1,
  parameter int AUTO_RESTART = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             resume,
  input  logic             abort,
  input  logic [CNT_W-1:0] len,
  output logic [1:0]       state,
  output logic             busy,
  output logic             run_en,
  output logic [CNT_W-1:0] count,
  output logic             done_pulse,
  output logic             early,
  output logic             aborted
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_RUNNING = 2'b01,
    S_PAUSED  = 2'b10,
    S_DONE    = 2'b11
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(DONE_HOLD - 1);
  localparam bit         AUTO      = (AUTO_RESTART != 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_d, len_q, len_d, count_inc;
  logic [7:0]       hold_q, hold_d;
  logic             pulse_d, early_d, aborted_d, begin_run;

  assign count_inc = count + CNT_W'(1);
  assign state     = state_q;
  assign busy      = (state_q == S_RUNNING) || (state_q == S_PAUSED);
  assign run_en    = (state_q == S_RUNNING);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      count      <= '0;
      len_q      <= '0;
      hold_q     <= '0;
      done_pulse <= 1'b0;
      early      <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count      <= count_d;
      len_q      <= len_d;
      hold_q     <= hold_d;
      done_pulse <= pulse_d;
      early      <= early_d;
      aborted    <= aborted_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count;
    len_d     = len_q;
    hold_d    = hold_q;
    pulse_d   = 1'b0;
    early_d   = early;
    aborted_d = aborted;
    begin_run = 1'b0;

    case (state_q)
      S_IDLE: begin
        begin_run = start;
      end
      S_RUNNING: begin
        // abort > stop > completion > pause; the stop/completion cycle itself counts
        if (abort) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else if (stop) begin
          state_d = S_DONE;
          count_d = count_inc;
          early_d = (count_inc < len_q);
          pulse_d = 1'b1;
          hold_d  = '0;
        end else if (count_inc == len_q) begin
          state_d = S_DONE;
          count_d = len_q;
          early_d = 1'b0;
          pulse_d = 1'b1;
          hold_d  = '0;
        end else if (pause) begin
          state_d = S_PAUSED;
        end else begin
          count_d = count_inc;
        end
      end
      S_PAUSED: begin
        if (abort) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else if (stop) begin
          state_d = S_DONE;
          early_d = (count != len_q);
          pulse_d = 1'b1;
          hold_d  = '0;
        end else if (resume) begin
          state_d = S_RUNNING;
        end
      end
      S_DONE: begin
        if (hold_q == HOLD_LAST) begin
          if (AUTO && start) begin
            begin_run = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A new run relatches len and clears the previous run's result flags.
    if (begin_run) begin
      len_d     = len;
      count_d   = '0;
      early_d   = 1'b0;
      aborted_d = 1'b0;
      hold_d    = '0;
      if (len == '0) begin
        state_d = S_DONE;
        pulse_d = 1'b1;
      end else begin
        state_d = S_RUNNING;
      end
    end
  end

endmodule

// File: tb/tb_run_ctrl_fsm.sv
// Bench for run_ctrl_fsm: two instances (plain, and hold=3 with auto-restart) share directed stimulus
// and are checked every cycle against a run-level behavioural model plus hand-computed expectations.
module tb_run_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, stop = 1'b0, pause = 1'b0, resume = 1'b0, abort = 1'b0;
  logic [3:0] len = 4'd0;

  logic [1:0] state_a, state_b;
  logic [3:0] count_a, count_b;
  logic       busy_a, run_en_a, done_pulse_a, early_a, aborted_a;
  logic       busy_b, run_en_b, done_pulse_b, early_b, aborted_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  run_ctrl_fsm #(.CNT_W(4), .DONE_HOLD(1), .AUTO_RESTART(0)) dut_a (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause), .resume(resume),
    .abort(abort), .len(len), .state(state_a), .busy(busy_a), .run_en(run_en_a),
    .count(count_a), .done_pulse(done_pulse_a), .early(early_a), .aborted(aborted_a)
  );

  run_ctrl_fsm #(.CNT_W(4), .DONE_HOLD(3), .AUTO_RESTART(1)) dut_b (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause), .resume(resume),
    .abort(abort), .len(len), .state(state_b), .busy(busy_b), .run_en(run_en_b),
    .count(count_b), .done_pulse(done_pulse_b), .early(early_b), .aborted(aborted_b)
  );

  // Run-level model: phase 0 idle, 1 running, 2 paused, 3 done; hold = cycles spent in DONE so far.
  typedef struct packed {
    int ph;
    int cnt;
    int len;
    int hold;
    bit pulse;
    bit early;
    bit aborted;
  } model_t;

  model_t ma, mb;

  function automatic model_t step(model_t m, int hold_cycles, bit auto_rs,
                                  bit st, bit sp, bit pa, bit re, bit ab, int ln);
    model_t n = m;
    bit go = 1'b0;
    n.pulse = 1'b0;
    case (m.ph)
      0: go = st;
      1: begin
        if (ab) begin
          n.ph = 0;
          n.aborted = 1'b1;
        end else if (sp || (m.cnt + 1 == m.len)) begin
          n.cnt   = m.cnt + 1;
          n.early = (n.cnt < m.len);
          n.ph    = 3;
          n.pulse = 1'b1;
          n.hold  = 1;
        end else if (pa) begin
          n.ph = 2;
        end else begin
          n.cnt = m.cnt + 1;
        end
      end
      2: begin
        if (ab) begin
          n.ph = 0;
          n.aborted = 1'b1;
        end else if (sp) begin
          n.early = (m.cnt != m.len);
          n.ph    = 3;
          n.pulse = 1'b1;
          n.hold  = 1;
        end else if (re) begin
          n.ph = 1;
        end
      end
      default: begin
        if (m.hold >= hold_cycles) begin
          if (auto_rs && st) go = 1'b1;
          else n.ph = 0;
        end else begin
          n.hold = m.hold + 1;
        end
      end
    endcase
    if (go) begin
      n.len = ln;
      n.cnt = 0;
      n.early = 1'b0;
      n.aborted = 1'b0;
      if (ln == 0) begin
        n.ph = 3;
        n.pulse = 1'b1;
        n.hold = 1;
      end else begin
        n.ph = 1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma <= '0;
      mb <= '0;
    end else begin
      ma <= step(ma, 1, 1'b0, start, stop, pause, resume, abort, int'(len));
      mb <= step(mb, 3, 1'b1, start, stop, pause, resume, abort, int'(len));
    end
  end

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      cmp("a_state", 32'(state_a), ma.ph);
      cmp("a_busy", 32'(busy_a), 32'(ma.ph == 1 || ma.ph == 2));
      cmp("a_run_en", 32'(run_en_a), 32'(ma.ph == 1));
      cmp("a_count", 32'(count_a), ma.cnt);
      cmp("a_done_pulse", 32'(done_pulse_a), 32'(ma.pulse));
      cmp("a_early", 32'(early_a), 32'(ma.early));
      cmp("a_aborted", 32'(aborted_a), 32'(ma.aborted));
      cmp("b_state", 32'(state_b), mb.ph);
      cmp("b_busy", 32'(busy_b), 32'(mb.ph == 1 || mb.ph == 2));
      cmp("b_run_en", 32'(run_en_b), 32'(mb.ph == 1));
      cmp("b_count", 32'(count_b), mb.cnt);
      cmp("b_done_pulse", 32'(done_pulse_b), 32'(mb.pulse));
      cmp("b_early", 32'(early_b), 32'(mb.early));
      cmp("b_aborted", 32'(aborted_b), 32'(mb.aborted));
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_start(input int l);
    len = 4'(l);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int k;
    wait_cyc(2);
    #1 rst = 1'b0;
    @(negedge clk);
    cmp("lit_reset_state", 32'(state_a), 0);
    cmp("lit_reset_count", 32'(count_a), 0);

    // Asynchronous reset in the middle of a run
    run_start(10);
    wait_cyc(4);
    cmp("lit_mid_count", 32'(count_a), 4);
    #2 rst = 1'b1;
    #1;
    cmp("lit_async_state", 32'(state_a), 0);
    cmp("lit_async_count", 32'(count_a), 0);
    cmp("lit_async_busy", 32'(busy_a), 0);
    cmp("lit_async_b_state", 32'(state_b), 0);
    @(negedge clk);
    #1 rst = 1'b0;
    wait_cyc(2);

    // Uninterrupted run, len=5
    run_start(5);
    cmp("lit_full_first", 32'(count_a), 0);
    wait_cyc(4);
    cmp("lit_full_last_run", 32'(count_a), 4);
    cmp("lit_full_run_en", 32'(run_en_a), 1);
    wait_cyc(1);
    cmp("lit_full_done_state", 32'(state_a), 3);
    cmp("lit_full_done_count", 32'(count_a), 5);
    cmp("lit_full_pulse", 32'(done_pulse_a), 1);
    cmp("lit_full_early", 32'(early_a), 0);
    wait_cyc(1);
    cmp("lit_full_idle", 32'(state_a), 0);
    cmp("lit_full_pulse_gone", 32'(done_pulse_a), 0);
    cmp("lit_b_still_done", 32'(state_b), 3);
    wait_cyc(4);

    // Pause held three cycles at count=2, then resume
    run_start(6);
    wait_cyc(2);
    pause = 1'b1;
    wait_cyc(3);
    cmp("lit_paused_state", 32'(state_a), 2);
    cmp("lit_paused_count", 32'(count_a), 2);
    pause = 1'b0;
    resume = 1'b1;
    wait_cyc(1);
    resume = 1'b0;
    wait_cyc(4);
    cmp("lit_pause_done", 32'(state_a), 3);
    cmp("lit_pause_count", 32'(count_a), 6);
    wait_cyc(4);

    // Early stop at count=3
    run_start(8);
    wait_cyc(3);
    stop = 1'b1;
    wait_cyc(1);
    stop = 1'b0;
    cmp("lit_stop_state", 32'(state_a), 3);
    cmp("lit_stop_count", 32'(count_a), 4);
    cmp("lit_stop_early", 32'(early_a), 1);
    wait_cyc(4);

    // Abort at count=2
    run_start(8);
    cmp("lit_restart_clears_early", 32'(early_a), 0);
    wait_cyc(2);
    abort = 1'b1;
    wait_cyc(1);
    abort = 1'b0;
    cmp("lit_abort_state", 32'(state_a), 0);
    cmp("lit_abort_flag", 32'(aborted_a), 1);
    cmp("lit_abort_no_pulse", 32'(done_pulse_a), 0);
    cmp("lit_abort_count", 32'(count_a), 2);
    wait_cyc(4);

    // Zero length goes straight to DONE
    run_start(0);
    cmp("lit_len0_state", 32'(state_a), 3);
    cmp("lit_len0_pulse", 32'(done_pulse_a), 1);
    cmp("lit_len0_count", 32'(count_a), 0);
    wait_cyc(4);

    // Maximum length, no wrap
    run_start(15);
    k = 0;
    while (state_a != 2'd3 && k < 20) begin
      @(negedge clk);
      k++;
    end
    cmp("lit_max_cycles", k, 15);
    cmp("lit_max_count", 32'(count_a), 15);
    wait_cyc(4);

    // Start and stop together in IDLE: start wins, stop acts next cycle
    len = 4'd5;
    start = 1'b1;
    stop = 1'b1;
    wait_cyc(1);
    start = 1'b0;
    cmp("lit_ss_state", 32'(state_a), 1);
    cmp("lit_ss_count", 32'(count_a), 0);
    wait_cyc(1);
    stop = 1'b0;
    cmp("lit_ss_done_count", 32'(count_a), 1);
    cmp("lit_ss_early", 32'(early_a), 1);
    wait_cyc(4);

    // Completion and pause on the same cycle: completion wins
    run_start(3);
    wait_cyc(2);
    pause = 1'b1;
    wait_cyc(1);
    pause = 1'b0;
    cmp("lit_cp_state", 32'(state_a), 3);
    cmp("lit_cp_count", 32'(count_a), 3);
    wait_cyc(4);

    // Stop while paused
    run_start(4);
    wait_cyc(1);
    pause = 1'b1;
    wait_cyc(1);
    pause = 1'b0;
    stop = 1'b1;
    wait_cyc(1);
    stop = 1'b0;
    cmp("lit_ps_state", 32'(state_a), 3);
    cmp("lit_ps_early", 32'(early_a), 1);
    wait_cyc(4);

    // Auto-restart with start held high (instance b: hold 3)
    len = 4'd2;
    start = 1'b1;
    wait_cyc(1);
    cmp("lit_ar_run", 32'(state_b), 1);
    wait_cyc(2);
    cmp("lit_ar_done", 32'(state_b), 3);
    cmp("lit_ar_pulse", 32'(done_pulse_b), 1);
    cmp("lit_ar_count", 32'(count_b), 2);
    wait_cyc(1);
    cmp("lit_ar_pulse_once", 32'(done_pulse_b), 0);
    wait_cyc(1);
    cmp("lit_ar_hold3", 32'(state_b), 3);
    wait_cyc(1);
    cmp("lit_ar_rerun", 32'(state_b), 1);
    cmp("lit_ar_recount", 32'(count_b), 0);
    wait_cyc(10);
    start = 1'b0;
    wait_cyc(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
